// File: rtl/ad9826_pkg.sv
// Shared definitions for the AD9826 serial-port responder.
//   - Frame geometry constants, register address map, FSM state type,
//     and a helper that maps a register address to its LSB in the packed
//     72-bit register file.
package ad9826_pkg;

    localparam int AD9826_FRAME_BITS = 16;
    localparam int AD9826_ADDR_BITS  = 3;
    localparam int AD9826_DATA_BITS  = 9;

    localparam logic [2:0] AD9826_REG_CONFIG    = 3'd0;
    localparam logic [2:0] AD9826_REG_MUX       = 3'd1;
    localparam logic [2:0] AD9826_REG_PGA_RED   = 3'd2;
    localparam logic [2:0] AD9826_REG_PGA_GREEN = 3'd3;
    localparam logic [2:0] AD9826_REG_PGA_BLUE  = 3'd4;
    localparam logic [2:0] AD9826_REG_OFS_RED   = 3'd5;
    localparam logic [2:0] AD9826_REG_OFS_GREEN = 3'd6;
    localparam logic [2:0] AD9826_REG_OFS_BLUE  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WDATA,
        ST_RDATA
    } ad9826_state_e;

    function automatic logic [6:0] reg_lsb(input logic [2:0] a);
        return 7'(a) * 7'd9;
    endfunction

endpackage

// File: rtl/ad9826_serial_target_pin_sync_edge.sv
// Pin synchronizer with edge detection.
//   clk, rst_n : system clock, async active-low reset
//   pin        : asynchronous input pin
//   level      : synchronized pin level (STAGES flops deep)
//   rise, fall : single-cycle pulses on synchronized level transitions
// RESET_VAL sets the synchronizer reset level so that an idle pin produces
// no spurious edge when reset is released.
module pin_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], pin};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/ad9826_serial_target.sv
// AD9826 3-wire serial port responder (SLOAD/SCLK/SDATA) holding the eight
// 9-bit registers. Oversamples the pins on clk.
//   ad_sload      : frame select, active low
//   ad_sclk       : serial clock, idle low, data sampled on rise
//   ad_sdata_i    : SDATA pin level
//   ad_sdata_o/oe : SDATA drive value / enable during read data phase
//   regs          : register file, reg[a] = regs[9*a +: 9]
//   wr_strobe     : 1-cycle pulse when a write frame commits
//   wr_addr       : address of last committed write
//   frame_err     : 1-cycle pulse when a frame closes with bit count != 16
//
// state   | meaning
// IDLE    | SLOAD high, waiting for frame start
// ADDR    | shifting R/W, address and don't-care bits (bits 0-6)
// WDATA   | shifting 9 write-data bits into shadow register
// RDATA   | presenting regs[addr] MSB first on SCLK falls
module ad9826_serial_target
    import ad9826_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter logic [71:0] REG_RESET   = 72'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ad_sload,
    input  logic        ad_sclk,
    input  logic        ad_sdata_i,
    output logic        ad_sdata_o,
    output logic        ad_sdata_oe,
    output logic [71:0] regs,
    output logic        wr_strobe,
    output logic [2:0]  wr_addr,
    output logic        frame_err
);

    localparam logic [4:0] CNT_HDR_LAST = 5'd6;
    localparam logic [4:0] CNT_FULL     = 5'(AD9826_FRAME_BITS);
    localparam logic [4:0] CNT_SAT      = 5'(AD9826_FRAME_BITS + 1);
    localparam logic [4:0] CNT_RD_LAST  = 5'(AD9826_FRAME_BITS - 1);

    logic sload_lvl, sload_rise, sload_fall;
    logic sclk_lvl, sclk_rise, sclk_fall;
    logic sdata_lvl;

    pin_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sload (
        .clk(clk), .rst_n(rst_n), .pin(ad_sload),
        .level(sload_lvl), .rise(sload_rise), .fall(sload_fall)
    );

    pin_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .pin(ad_sclk),
        .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );

    pin_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdata (
        .clk(clk), .rst_n(rst_n), .pin(ad_sdata_i),
        .level(sdata_lvl), .rise(), .fall()
    );

    ad9826_state_e state, state_next;
    logic [4:0]    bit_cnt, cnt_eff;
    logic          rw, rw_eff;
    logic [2:0]    addr, addr_eff;
    logic [8:0]    shadow, shadow_eff;
    logic [8:0]    rd_shift;
    logic [71:0]   regs_q;
    logic          do_commit, do_err, do_rd_load;

    // The *_eff values include an SCLK rise arriving in this same cycle, so
    // a frame closing together with its last rise still sees that bit.
    always_comb begin
        state_next = state;
        cnt_eff    = bit_cnt;
        rw_eff     = rw;
        addr_eff   = addr;
        shadow_eff = shadow;
        do_commit  = 1'b0;
        do_err     = 1'b0;
        do_rd_load = 1'b0;

        if (state != ST_IDLE && sclk_rise) begin
            if (bit_cnt != CNT_SAT)
                cnt_eff = bit_cnt + 5'd1;
            if (state == ST_ADDR) begin
                if (bit_cnt == 5'd0)
                    rw_eff = sdata_lvl;
                else if (bit_cnt <= 5'd3)
                    addr_eff = {addr[1:0], sdata_lvl};
                if (bit_cnt == CNT_HDR_LAST) begin
                    state_next = rw ? ST_RDATA : ST_WDATA;
                    do_rd_load = rw;
                end
            end
            if (state == ST_WDATA)
                shadow_eff = {shadow[7:0], sdata_lvl};
        end

        if (sload_fall) begin
            state_next = ST_ADDR;
            do_rd_load = 1'b0;
        end else if (sload_rise) begin
            state_next = ST_IDLE;
            if (state != ST_IDLE) begin
                do_err    = (cnt_eff != CNT_FULL);
                do_commit = (state == ST_WDATA) && (cnt_eff == CNT_FULL);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt     <= '0;
            rw          <= 1'b0;
            addr        <= '0;
            shadow      <= '0;
            rd_shift    <= '0;
            regs_q      <= REG_RESET;
            wr_strobe   <= 1'b0;
            wr_addr     <= '0;
            frame_err   <= 1'b0;
            ad_sdata_o  <= 1'b0;
            ad_sdata_oe <= 1'b0;
        end else begin
            wr_strobe <= do_commit;
            frame_err <= do_err;

            if (sload_fall) begin
                bit_cnt <= '0;
                rw      <= 1'b0;
                addr    <= '0;
                shadow  <= '0;
            end else begin
                bit_cnt <= cnt_eff;
                rw      <= rw_eff;
                addr    <= addr_eff;
                shadow  <= shadow_eff;
            end

            if (do_commit) begin
                regs_q[reg_lsb(addr_eff) +: AD9826_DATA_BITS] <= shadow_eff;
                wr_addr <= addr_eff;
            end

            if (do_rd_load)
                rd_shift <= regs_q[reg_lsb(addr_eff) +: AD9826_DATA_BITS];

            // Drive D8..D0 on the falls following rises 7..15; the fall after
            // the 16th rise releases the pin.
            if (sload_rise || sload_fall) begin
                ad_sdata_oe <= 1'b0;
            end else if (state == ST_RDATA && sclk_fall) begin
                if (bit_cnt <= CNT_RD_LAST) begin
                    ad_sdata_oe <= 1'b1;
                    ad_sdata_o  <= rd_shift[8];
                    rd_shift    <= {rd_shift[7:0], 1'b0};
                end else begin
                    ad_sdata_oe <= 1'b0;
                end
            end
        end
    end

    assign regs = regs_q;

endmodule

// File: tb/tb_ad9826_serial_target.sv
module tb_ad9826_serial_target;

    localparam logic [71:0] RST_VAL = 72'h12_3456_789A_BCDE_F012;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ad_sload = 1'b1;
    logic        ad_sclk = 1'b0;
    logic        ad_sdata_i = 1'b0;
    logic        ad_sdata_o;
    logic        ad_sdata_oe;
    logic [71:0] regs;
    logic        wr_strobe;
    logic [2:0]  wr_addr;
    logic        frame_err;

    ad9826_serial_target #(.SYNC_STAGES(2), .REG_RESET(RST_VAL)) dut (
        .clk(clk), .rst_n(rst_n), .ad_sload(ad_sload), .ad_sclk(ad_sclk),
        .ad_sdata_i(ad_sdata_i), .ad_sdata_o(ad_sdata_o), .ad_sdata_oe(ad_sdata_oe),
        .regs(regs), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int err_seen = 0;
    int strobe_seen = 0;
    logic [11:0] sb[$];
    logic [11:0] sb_e;
    logic [8:0]  mdl[8];
    logic [71:0] rst_vec;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] mdl_pack();
        logic [71:0] v;
        for (int k = 0; k < 8; k++) v[9*k +: 9] = mdl[k];
        return v;
    endfunction

    task automatic mdl_reset();
        for (int k = 0; k < 8; k++) mdl[k] = rst_vec[9*k +: 9];
    endtask

    // Scoreboard: expected commits are pushed when a write frame is driven.
    always @(negedge clk) begin
        if (frame_err === 1'b1) err_seen++;
        if (wr_strobe === 1'b1) begin
            strobe_seen++;
            if (sb.size() == 0) begin
                chk("unexpected_strobe", wr_strobe, 1'b0);
            end else begin
                sb_e = sb.pop_front();
                chk("sb_wr_addr", wr_addr, sb_e[11:9]);
                chk("sb_wr_data", regs[9*sb_e[11:9] +: 9], sb_e[8:0]);
            end
        end
    end

    // Master-side frame: n SCLK pulses at 6.25 MHz. Samples SDATA on rises
    // for bits 7..15 and tallies oe mismatches. rst_at >= 0 pulls reset low
    // right after that rise and aborts the frame.
    task automatic frame(input logic rw, input logic [2:0] a, input logic [8:0] d,
                         input int n, input int rst_at, input int gap,
                         output logic [8:0] rd, output int oe_bad);
        logic [15:0] w;
        logic        oe_exp;
        w = {rw, a, 3'b000, d};
        rd = '0;
        oe_bad = 0;
        ad_sload = 1'b0;
        #200;
        for (int i = 0; i < n; i++) begin
            ad_sdata_i = (i < 16) ? w[15-i] : 1'b0;
            #80 ad_sclk = 1'b1;
            if (i >= 7 && i <= 15) rd[15-i] = ad_sdata_o;
            oe_exp = rw && (i >= 7) && (i <= 15);
            if (ad_sdata_oe !== oe_exp) oe_bad++;
            if (i == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_mid_oe", ad_sdata_oe, 1'b0);
                chk("rst_mid_regs", regs, rst_vec);
                break;
            end
            #80 ad_sclk = 1'b0;
        end
        ad_sclk = 1'b0;
        #200 ad_sload = 1'b1;
        #(gap);
    endtask

    task automatic wr(input logic [2:0] a, input logic [8:0] d, input int gap);
        logic [8:0] rd;
        int         bad;
        sb.push_back({a, d});
        mdl[a] = d;
        frame(1'b0, a, d, 16, -1, gap, rd, bad);
        chk("wr_oe_never", bad, 0);
    endtask

    logic [8:0] rd;
    int         bad;

    initial begin
        rst_vec = RST_VAL;
        mdl_reset();
        #40;
        chk("rst_regs", regs, rst_vec);
        chk("rst_oe", ad_sdata_oe, 1'b0);
        chk("rst_sdata_o", ad_sdata_o, 1'b0);
        chk("rst_strobe", wr_strobe, 1'b0);
        chk("rst_wr_addr", wr_addr, 3'd0);
        chk("rst_frame_err", frame_err, 1'b0);
        rst_n = 1'b1;
        #100;

        // Basic write to CONFIG
        wr(3'd0, 9'h1A5, 200);
        chk("w0_regs", regs, mdl_pack());
        chk("w0_strobes", strobe_seen, 1);
        chk("w0_err", err_seen, 0);
        chk("w0_wr_addr", wr_addr, 3'd0);

        // Write then read back address 5
        wr(3'd5, 9'h0FF, 200);
        frame(1'b1, 3'd5, 9'h000, 16, -1, 200, rd, bad);
        chk("rd5_data", rd, 9'h0FF);
        chk("rd5_oe_window", bad, 0);
        chk("rd5_oe_after", ad_sdata_oe, 1'b0);
        chk("rd5_regs", regs, mdl_pack());
        chk("rd5_strobes", strobe_seen, 2);
        chk("rd5_err", err_seen, 0);

        // Read untouched reset value at address 2
        frame(1'b1, 3'd2, 9'h1FF, 16, -1, 200, rd, bad);
        chk("rd2_data", rd, rst_vec[18 +: 9]);
        chk("rd2_oe_window", bad, 0);

        // Short write frame: 12 SCLKs
        frame(1'b0, 3'd1, 9'h055, 12, -1, 200, rd, bad);
        chk("short_err", err_seen, 1);
        chk("short_regs", regs, mdl_pack());
        chk("short_strobes", strobe_seen, 2);

        // Long write frame: 17 SCLKs, then a good frame
        frame(1'b0, 3'd3, 9'h0AA, 17, -1, 200, rd, bad);
        chk("long_err", err_seen, 2);
        chk("long_regs", regs, mdl_pack());
        chk("long_strobes", strobe_seen, 2);
        wr(3'd3, 9'h133, 200);
        chk("after_long_regs", regs, mdl_pack());
        chk("after_long_wr_addr", wr_addr, 3'd3);
        chk("after_long_err", err_seen, 2);

        // Frame with no SCLK at all
        frame(1'b0, 3'd6, 9'h000, 0, -1, 200, rd, bad);
        chk("empty_err", err_seen, 3);
        chk("empty_regs", regs, mdl_pack());

        // Reset during bit 10 of a read frame
        frame(1'b1, 3'd0, 9'h000, 16, 10, 200, rd, bad);
        mdl_reset();
        #9 rst_n = 1'b1;
        #100;
        chk("post_rst_regs", regs, mdl_pack());
        chk("post_rst_strobes", strobe_seen, 3);
        wr(3'd7, 9'h155, 200);
        chk("post_rst_wr_regs", regs, mdl_pack());
        chk("post_rst_wr_addr", wr_addr, 3'd7);

        // Back-to-back frames with a 2-clock SLOAD-high gap
        wr(3'd4, 9'h0C3, 20);
        wr(3'd6, 9'h13C, 200);
        chk("b2b_regs", regs, mdl_pack());
        chk("b2b_strobes", strobe_seen, 6);
        chk("b2b_wr_addr", wr_addr, 3'd6);
        chk("final_err", err_seen, 3);
        chk("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
